mem_master: RTL and testbench

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_master.sv | 152 +++++++++++++++
 tb/tb_mem_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// Memory master: 2-deep prefetching instruction fetcher plus a one-access data port.
// Optional address bounds checking on the data port is enabled by defining MEM_MASTER_BOUNDS_EN.
module mem_master #(
  parameter int          MEM_WORDS = 128,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  output logic        instr_valid,
  output logic [15:0] instr,
  input  logic        instr_ready,
  input  logic        dreq_valid,
  input  logic        dreq_we,
  input  logic [15:0] dreq_addr,
  input  logic [15:0] dreq_wdata,
  output logic        dreq_ready,
  output logic        drsp_valid,
  output logic        drsp_err,
  output logic [15:0] drsp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_d_addr,
  output logic [15:0] mem_i_addr,
  inout  wire  [15:0] mem_d_bus,
  input  logic [15:0] mem_i_bus
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and the producer holds its payload until the transfer.

  // ---------------- instruction side ----------------
  logic [15:0] fetch_pc;
  logic [15:0] fifo_head;
  logic [15:0] fifo_tail;
  logic [1:0]  fifo_count;
  logic        in_flight;
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ_eff;

  assign instr_valid = (fifo_count != 2'd0);
  assign instr       = fifo_head;
  assign mem_i_addr  = fetch_pc;
  assign pop         = instr_valid && instr_ready;
  assign push        = in_flight;
  // Credit the same-cycle pop so a continuously ready consumer sees one word per cycle.
  assign occ_eff     = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, in_flight};
  assign issue       = (occ_eff < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      fifo_head  <= 16'h0000;
      fifo_tail  <= 16'h0000;
      fifo_count <= 2'd0;
      in_flight  <= 1'b0;
    end else if (pc_load) begin
      fetch_pc   <= pc_target;
      fifo_count <= 2'd0;
      in_flight  <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) fetch_pc <= fetch_pc + 16'd1;
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) fifo_head <= mem_i_bus;
          else                    fifo_tail <= mem_i_bus;
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          fifo_head  <= fifo_tail;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            fifo_head <= mem_i_bus;
          end else begin
            fifo_head <= fifo_tail;
            fifo_tail <= mem_i_bus;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- data side ----------------
  typedef enum logic {IDLE, ACC} dstate_t;
  dstate_t     dstate;
  logic [15:0] lat_wdata;
  logic        lat_err;
  logic        oob;

`ifdef MEM_MASTER_BOUNDS_EN
  logic err_q;
  assign oob      = (32'(dreq_addr) >= 32'(MEM_WORDS));
  assign drsp_err = err_q;
`else
  assign oob      = 1'b0;
  assign drsp_err = 1'b0;
`endif

  assign dreq_ready = (dstate == IDLE);
  assign mem_d_bus  = mem_write ? lat_wdata : 16'hzzzz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstate     <= IDLE;
      lat_wdata  <= 16'h0000;
      lat_err    <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_d_addr <= 16'h0000;
      drsp_valid <= 1'b0;
      drsp_rdata <= 16'h0000;
`ifdef MEM_MASTER_BOUNDS_EN
      err_q      <= 1'b0;
`endif
    end else begin
      drsp_valid <= 1'b0;
      case (dstate)
        IDLE: begin
          if (dreq_valid) begin
            dstate     <= ACC;
            lat_wdata  <= dreq_wdata;
            lat_err    <= oob;
            mem_d_addr <= dreq_addr;
            mem_read   <= !dreq_we && !oob;
            mem_write  <= dreq_we && !oob;
          end
        end
        ACC: begin
          dstate     <= IDLE;
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          drsp_valid <= 1'b1;
`ifdef MEM_MASTER_BOUNDS_EN
          err_q      <= lat_err;
`endif
          // Read data is sampled from the bus while the memory is still driving it.
          if (lat_err)       drsp_rdata <= 16'h0000;
          else if (mem_read) drsp_rdata <= mem_d_bus;
        end
        default: dstate <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: behavioural memory, directed stimulus and a queue-based scoreboard
// for instruction words and data responses.
`timescale 1ns/1ps
module tb_mem_master;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_target = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready = 1'b0;
  logic        dreq_valid = 1'b0;
  logic        dreq_we = 1'b0;
  logic [15:0] dreq_addr = 16'h0000;
  logic [15:0] dreq_wdata = 16'h0000;
  logic        dreq_ready;
  logic        drsp_valid;
  logic        drsp_err;
  logic [15:0] drsp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_d_addr;
  logic [15:0] mem_i_addr;
  wire  [15:0] mem_d_bus;
  logic [15:0] mem_i_bus = 16'h0000;

  logic [15:0] mem [0:255];
  logic [15:0] exp_i[$];
  logic [16:0] exp_d[$];
  int n_cmp = 0;
  int n_fail = 0;

  mem_master #(.MEM_WORDS(128), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .pc_target(pc_target),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .dreq_valid(dreq_valid), .dreq_we(dreq_we), .dreq_addr(dreq_addr),
    .dreq_wdata(dreq_wdata), .dreq_ready(dreq_ready),
    .drsp_valid(drsp_valid), .drsp_err(drsp_err), .drsp_rdata(drsp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_d_addr(mem_d_addr),
    .mem_i_addr(mem_i_addr), .mem_d_bus(mem_d_bus), .mem_i_bus(mem_i_bus)
  );

  // ---------------- clock and memory model ----------------
  always #5 clk = ~clk;

  assign mem_d_bus = mem_read ? mem[mem_d_addr[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    mem_i_bus <= mem[mem_i_addr[7:0]];
    if (mem_write) mem[mem_d_addr[7:0]] = mem_d_bus;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [15:0] e_i;
  logic [16:0] e_d;
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      if (exp_i.size() == 0) begin
        check("instr_unexpected", {16'h0, instr}, 32'hFFFF_FFFF);
      end else begin
        e_i = exp_i.pop_front();
        check("instr_word", {16'h0, instr}, {16'h0, e_i});
      end
    end
    if (rst_n && drsp_valid) begin
      if (exp_d.size() == 0) begin
        check("drsp_unexpected", {15'h0, drsp_err, drsp_rdata}, 32'hFFFF_FFFF);
      end else begin
        e_d = exp_d.pop_front();
        check("drsp_err_rdata", {15'h0, drsp_err, drsp_rdata}, {15'h0, e_d});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic consume(input int k);
    int n;
    n = 0;
    @(posedge clk); #1 instr_ready = 1'b1;
    for (int c = 0; c < 40 && n < k; c++) begin
      @(negedge clk);
      if (instr_valid) n++;
    end
    check("consume_count", n, k);
    @(posedge clk); #1 instr_ready = 1'b0;
  endtask

  task automatic data_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic exp_err, input logic [15:0] exp_rdata,
                          input logic exp_strobe, input string tag);
    @(posedge clk); #1;
    dreq_valid = 1'b1; dreq_we = we; dreq_addr = addr; dreq_wdata = wdata;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dreq_ready) break;
    end
    check({tag, "_ready"}, {31'h0, dreq_ready}, 32'h1);
    exp_d.push_back({exp_err, exp_rdata});
    @(posedge clk); #1 dreq_valid = 1'b0;
    @(negedge clk);
    check({tag, "_acc_write"}, {31'h0, mem_write}, {31'h0, we & exp_strobe});
    check({tag, "_acc_read"}, {31'h0, mem_read}, {31'h0, ~we & exp_strobe});
    check({tag, "_acc_busy"}, {31'h0, dreq_ready}, 32'h0);
    if (exp_strobe) check({tag, "_acc_addr"}, {16'h0, mem_d_addr}, {16'h0, addr});
    if (we && exp_strobe) check({tag, "_acc_bus"}, {16'h0, mem_d_bus}, {16'h0, wdata});
    check({tag, "_rsp_early"}, {31'h0, drsp_valid}, 32'h0);
    @(negedge clk);
    check({tag, "_rsp_valid"}, {31'h0, drsp_valid}, 32'h1);
    check({tag, "_strobes_off"}, {30'h0, mem_read, mem_write}, 32'h0);
    @(negedge clk);
    check({tag, "_rsp_pulse"}, {31'h0, drsp_valid}, 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    for (int i = 0; i < 256; i++) mem[i] = 16'h5A00 | 16'(i);
    mem[0] = 16'hFF1A; mem[1] = 16'hAAAA; mem[2] = 16'hFF3A;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", {16'h0, instr}, 32'h0);
    check("rst_drsp_valid", {31'h0, drsp_valid}, 32'h0);
    check("rst_drsp_err", {31'h0, drsp_err}, 32'h0);
    check("rst_drsp_rdata", {16'h0, drsp_rdata}, 32'h0);
    check("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    check("rst_mem_d_addr", {16'h0, mem_d_addr}, 32'h0);
    check("rst_mem_i_addr", {16'h0, mem_i_addr}, {16'h0, RESET_PC});
    check("rst_dreq_ready", {31'h0, dreq_ready}, 32'h1);

    // Streaming fetch from reset with a ready consumer
    instr_ready = 1'b1;
    exp_i.push_back(16'hFF1A); exp_i.push_back(16'hAAAA); exp_i.push_back(16'hFF3A);
    rst_n = 1'b1;
    @(negedge clk) check("stream_valid_c1", {31'h0, instr_valid}, 32'h0);
    @(negedge clk) check("stream_valid_c2", {31'h0, instr_valid}, 32'h1);
    @(negedge clk) check("stream_valid_c3", {31'h0, instr_valid}, 32'h1);
    @(negedge clk) check("stream_valid_c4", {31'h0, instr_valid}, 32'h1);
    @(posedge clk); #1 instr_ready = 1'b0;

    // Stalled consumer: fetch stops at two words
    pulse_reset();
    repeat (10) @(negedge clk);
    check("stall_fetch_pc", {16'h0, mem_i_addr}, {16'h0, RESET_PC + 16'd2});
    check("stall_valid", {31'h0, instr_valid}, 32'h1);
    exp_i.push_back(16'hFF1A); exp_i.push_back(16'hAAAA);
    consume(2);

    // Branch while a fetch is in flight
    pulse_reset();
    @(posedge clk); #1 pc_load = 1'b1; pc_target = 16'h0004;
    @(posedge clk); #1 pc_load = 1'b0;
    @(negedge clk);
    check("branch_flush_valid", {31'h0, instr_valid}, 32'h0);
    check("branch_fetch_pc", {16'h0, mem_i_addr}, 32'h0004);
    @(negedge clk) check("branch_drop_inflight", {31'h0, instr_valid}, 32'h0);
    exp_i.push_back(16'h5A04); exp_i.push_back(16'h5A05);
    consume(2);

    // Data accesses
    data_req(1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0000, 1'b1, "wr10");
    check("mem_written", {16'h0, mem[16]}, 32'h1234);
    data_req(1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234, 1'b1, "rd10");
    data_req(1'b0, 16'h0003, 16'h0000, 1'b0, 16'h5A03, 1'b1, "rd03");
    data_req(1'b1, 16'h0011, 16'h00FF, 1'b0, 16'h5A03, 1'b1, "wr11_hold");
    data_req(1'b0, 16'h007F, 16'h0000, 1'b0, 16'h5A7F, 1'b1, "rd7f_edge");
`ifdef MEM_MASTER_BOUNDS_EN
    data_req(1'b0, 16'h0080, 16'h0000, 1'b1, 16'h0000, 1'b0, "rd80_oob");
    data_req(1'b1, 16'h0090, 16'hDEAD, 1'b1, 16'h0000, 1'b0, "wr90_oob");
    check("oob_no_write", {16'h0, mem[8'h90]}, 32'h5A90);
`else
    data_req(1'b0, 16'h0080, 16'h0000, 1'b0, 16'h5A80, 1'b1, "rd80");
`endif

    // Reset in the middle of a write access
    @(posedge clk); #1;
    dreq_valid = 1'b1; dreq_we = 1'b1; dreq_addr = 16'h0020; dreq_wdata = 16'hBEEF;
    @(negedge clk) check("abort_ready", {31'h0, dreq_ready}, 32'h1);
    @(posedge clk); #1 dreq_valid = 1'b0;
    #1;
    check("abort_write_on", {31'h0, mem_write}, 32'h1);
    check("abort_bus_drive", {16'h0, mem_d_bus}, 32'hBEEF);
    rst_n = 1'b0;
    #1;
    check("abort_write_drop", {31'h0, mem_write}, 32'h0);
    check("abort_d_addr", {16'h0, mem_d_addr}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (drsp_valid) seen++;
    end
    check("abort_no_rsp", seen, 0);
    check("abort_mem_untouched", {16'h0, mem[8'h20]}, 32'h5A20);

    check("instr_queue_drained", exp_i.size(), 0);
    check("drsp_queue_drained", exp_d.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, time %0t limit 200000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
